// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC core scheduler.
package cordic_sched_pkg;
  typedef enum logic [2:0] {IDLE, CLR, START, RUN, DONE} state_t;

  localparam int ITER_DEF = 10;
  localparam int WI_DEF   = 16;
  localparam int WF_DEF   = 16;
  localparam int ANG_W    = WI_DEF + WF_DEF;

  // core_out packing: {sext cos Q2.8, sext sin Q2.8}
  localparam int COS_HI = 31;
  localparam int COS_LO = 16;
  localparam int SIN_HI = 15;
  localparam int SIN_LO = 0;
endpackage

// File: rtl/cordic_sched_if.sv
// Requester/response bus of the CORDIC scheduler: request+angle in, grant and id-tagged result out.
interface cordic_sched_if #(
  parameter int NREQ = 4,
  parameter int WI   = 16,
  parameter int WF   = 16,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][WI+WF-1:0]  angle_in;
  logic [NREQ-1:0]             gnt;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IDW-1:0]              rsp_id;
  logic [31:0]                 rsp_data;

  modport slave  (input  req, angle_in, rsp_ready, output gnt, rsp_valid, rsp_id, rsp_data);
  modport master (output req, angle_in, rsp_ready, input  gnt, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/cordic_sched_rr_arb.sv
// Combinational NREQ-way arbiter: round-robin after ptr, or lowest index first
// when CORDIC_SCHED_FIXED_PRIO_EN is defined.
module cordic_sched_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  idx
);
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan downwards so the lowest requesting index is the last writer.
  always_comb begin
    win = '0;
    idx = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (req[j]) begin
        win = '0;
        win[j] = 1'b1;
        idx = IDW'(j);
      end
    end
  end
`else
  logic [IDW-1:0] j;
  logic           found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        win[j] = 1'b1;
        idx    = j;
      end
    end
  end
`endif
endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative CORDIC core among NREQ requesters and returns id-tagged results.
// Build option: CORDIC_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WI   = WI_DEF,
  parameter int WF   = WF_DEF,
  parameter int ITER = ITER_DEF,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  cordic_sched_if.slave     bus,
  output logic              core_rst,
  output logic              core_start,
  output logic              core_en,
  output logic [WI+WF-1:0]  core_angle,
  input  logic [31:0]       core_out
);
  localparam int CW = $clog2(ITER + 1);

  state_t          state, nstate;
  logic [IDW-1:0]  id_q, ptr, win_idx;
  logic [NREQ-1:0] win;
  logic [CW-1:0]   iter_cnt;
  logic            take, last, rsp_load;

  assign take     = (state == IDLE) && (|bus.req);
  assign last     = (iter_cnt == CW'(ITER - 1));
  assign rsp_load = (state == DONE) && (!bus.rsp_valid || bus.rsp_ready);

`ifdef CORDIC_SCHED_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       ptr <= IDW'(NREQ - 1);
    else if (take) ptr <= win_idx;
  end
`endif

  cordic_sched_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx)
  );

  always_comb begin
    nstate     = state;
    core_start = 1'b0;
    core_en    = 1'b0;
    core_rst   = RST;
    bus.gnt    = '0;
    case (state)
      IDLE:  if (take) nstate = CLR;
      CLR: begin
        core_rst         = 1'b1;
        bus.gnt[id_q]    = 1'b1;
        nstate           = START;
      end
      START: begin
        core_start = 1'b1;
        nstate     = RUN;
      end
      RUN: begin
        core_en = 1'b1;
        if (last) nstate = DONE;
      end
      DONE:  if (rsp_load) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      id_q          <= '0;
      core_angle    <= '0;
      iter_cnt      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      state <= nstate;
      // Angle is captured once per job and held until the result is taken.
      if (take) begin
        id_q       <= win_idx;
        core_angle <= bus.angle_in[win_idx];
      end
      if (state == START)    iter_cnt <= CW'(1);
      else if (state == RUN) iter_cnt <= iter_cnt + CW'(1);
      if (rsp_load) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= id_q;
        bus.rsp_data  <= {core_out[COS_HI:COS_LO], core_out[SIN_HI:SIN_LO]};
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

  logic unused_win;
  assign unused_win = ^win;
endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched with a behavioural iterative core that only yields the
// true cos/sin after exactly ITER start+enable cycles on a stable angle.
module tb_cordic_sched;
  localparam int NREQ = 4, WI = 16, WF = 16, ITER = 10, IDW = 2;
  localparam int LAT = ITER + 2, PER = ITER + 3;
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cordic_sched_if #(.NREQ(NREQ), .WI(WI), .WF(WF), .IDW(IDW)) bus ();
  logic        core_rst, core_start, core_en;
  logic [31:0] core_angle, core_out;

  cordic_sched #(.NREQ(NREQ), .WI(WI), .WF(WF), .ITER(ITER), .IDW(IDW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .core_rst   (core_rst),
    .core_start (core_start),
    .core_en    (core_en),
    .core_angle (core_angle),
    .core_out   (core_out)
  );

  function automatic logic [31:0] lut(input logic [15:0] deg);
    case (deg)
      16'd0:   return 32'h0100_0000;
      16'd30:  return 32'h00DD_0080;
      16'd45:  return 32'h00B5_00B5;
      16'd90:  return 32'h0000_0100;
      16'd150: return 32'hFF23_0080;
      default: return {deg, deg};
    endcase
  endfunction

  // Core model: counts start + enables, flags any angle change while iterating.
  logic [4:0]  ccnt;
  logic [31:0] cang;
  logic        aok;
  always_ff @(posedge CLK) begin
    if (core_rst) begin
      ccnt <= '0; cang <= '0; aok <= 1'b1;
    end else if (core_start) begin
      ccnt <= 5'd1; cang <= core_angle; aok <= 1'b1;
    end else if (core_en) begin
      ccnt <= ccnt + 5'd1;
      if (core_angle != cang) aok <= 1'b0;
    end
  end
  assign core_out = (ccnt == 5'(ITER) && aok) ? lut(cang[31:16]) : {16'hDEAD, 11'h0, ccnt};

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int ntests = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_cs(input string nm, input logic [31:0] act, input logic [31:0] exp);
    int dc, ds;
    dc = int'($signed(act[31:16])) - int'($signed(exp[31:16]));
    ds = int'($signed(act[15:0]))  - int'($signed(exp[15:0]));
    ntests++;
    if (dc > 2 || dc < -2 || ds > 2 || ds < -2) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (+-2 lsb)", nm, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] g);
    int r = -1, c = 0;
    for (int i = 0; i < 4; i++) if (g[i]) begin r = i; c++; end
    if (c > 1) r = 99;
    return r;
  endfunction

  task automatic wait_rsp(input int lim, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < lim && !ok; n++) begin
      @(negedge CLK);
      if (bus.rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " gnt"},        32'(bus.gnt), 32'h0);
    chk({nm, " core_start"}, 32'(core_start), 32'h0);
    chk({nm, " core_en"},    32'(core_en), 32'h0);
    chk({nm, " core_rst"},   32'(core_rst), 32'h1);
    chk({nm, " core_angle"}, core_angle, 32'h0);
    chk({nm, " rsp_valid"},  32'(bus.rsp_valid), 32'h0);
    chk({nm, " rsp_id"},     32'(bus.rsp_id), 32'h0);
    chk({nm, " rsp_data"},   bus.rsp_data, 32'h0);
  endtask

  typedef struct { int id; logic [31:0] ang; logic [31:0] exp; } vec_t;
  vec_t vt[6];

  task automatic run_vec(input vec_t v, input string nm);
    int g0;
    bit ok;
    @(negedge CLK);
    bus.req[v.id] = 1'b1;
    bus.angle_in[v.id] = v.ang;
    @(negedge CLK);
    chk({nm, " gnt"}, 32'(bus.gnt), 32'(1 << v.id));
    g0 = cyc;
    bus.req[v.id] = 1'b0;
    wait_rsp(40, ok);
    chk({nm, " done"}, 32'(ok), 32'h1);
    chk({nm, " latency"}, 32'(cyc - g0), 32'(LAT));
    chk({nm, " id"}, 32'(bus.rsp_id), 32'(v.id));
    chk_cs({nm, " data"}, bus.rsp_data, v.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int gord[$], gcyc[$], rid[$];
    logic [31:0] rdat[$];
    logic [31:0] d0;
    int i0, efirst, esecond;
    bit ok, stable;

    RST = 1'b1;
    bus.req = '0;
    bus.angle_in = '0;
    bus.rsp_ready = 1'b1;
    #1;
    chk_reset("reset");
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    vt[0] = '{0, 32'h001E_0000, 32'h00DD_0080};
    vt[1] = '{1, 32'h0096_0000, 32'hFF23_0080};
    vt[2] = '{2, 32'h002D_0000, 32'h00B5_00B5};
    vt[3] = '{3, 32'h005A_0000, 32'h0000_0100};
    vt[4] = '{2, 32'h0000_0000, 32'h0100_0000};
    vt[5] = '{0, 32'h0000_0000, 32'h0100_0000};
    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Simultaneous req[1] (150 deg) and req[3] (0 deg).
    @(negedge CLK);
    bus.angle_in[1] = 32'h0096_0000;
    bus.angle_in[3] = 32'h0000_0000;
    bus.req = 4'b1010;
    for (int n = 0; n < 80 && rid.size() < 2; n++) begin
      @(negedge CLK);
      if (|bus.gnt) begin gord.push_back(oh2i(bus.gnt)); bus.req = bus.req & ~bus.gnt; end
      if (bus.rsp_valid) begin rid.push_back(int'(bus.rsp_id)); rdat.push_back(bus.rsp_data); end
    end
    while (gord.size() < 2) gord.push_back(-1);
    while (rid.size() < 2) begin rid.push_back(-1); rdat.push_back(32'hFFFF_FFFF); end
    chk("pair gnt0", 32'(gord[0]), 32'd1);
    chk("pair gnt1", 32'(gord[1]), 32'd3);
    chk("pair rsp0 id", 32'(rid[0]), 32'd1);
    chk_cs("pair rsp0 data", rdat[0], 32'hFF23_0080);
    chk("pair rsp1 id", 32'(rid[1]), 32'd3);
    chk_cs("pair rsp1 data", rdat[1], 32'h0100_0000);

    // All requesters held: rotation (or starvation under fixed priority) and spacing.
    gord.delete();
    @(negedge CLK);
    bus.angle_in = '0;
    bus.req = 4'b1111;
    for (int n = 0; n < 120 && gord.size() < 5; n++) begin
      @(negedge CLK);
      if (|bus.gnt) begin gord.push_back(oh2i(bus.gnt)); gcyc.push_back(cyc); end
    end
    bus.req = '0;
    while (gord.size() < 5) begin gord.push_back(-1); gcyc.push_back(0); end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("all4 gnt%0d", k), 32'(gord[k]), FIXED ? 32'd0 : 32'(k % 4));
      if (k > 0) chk($sformatf("all4 gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'(PER));
    end
    wait_rsp(40, ok);
    chk("all4 last rsp", 32'(ok), 32'h1);
    @(negedge CLK);

    // Backpressure: two jobs, response held for 20 cycles.
    efirst  = FIXED ? 0 : 2;
    esecond = FIXED ? 2 : 0;
    bus.rsp_ready = 1'b0;
    bus.angle_in[0] = 32'h001E_0000;
    bus.angle_in[2] = 32'h005A_0000;
    bus.req = 4'b0101;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge CLK);
      bus.req = bus.req & ~bus.gnt;
      if (bus.rsp_valid) ok = 1'b1;
    end
    chk("stall first rsp", 32'(ok), 32'h1);
    d0 = bus.rsp_data;
    i0 = int'(bus.rsp_id);
    stable = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      bus.req = bus.req & ~bus.gnt;
      if (!bus.rsp_valid || bus.rsp_data !== d0 || int'(bus.rsp_id) != i0) stable = 1'b0;
    end
    chk("stall held", 32'(stable), 32'h1);
    chk("stall id", 32'(i0), 32'(efirst));
    chk_cs("stall data", d0, efirst == 2 ? 32'h0000_0100 : 32'h00DD_0080);
    chk("stall both granted", 32'(bus.req), 32'h0);
    chk("stall core_en off", 32'(core_en), 32'h0);
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    chk("b2b valid", 32'(bus.rsp_valid), 32'h1);
    chk("b2b id", 32'(bus.rsp_id), 32'(esecond));
    chk_cs("b2b data", bus.rsp_data, esecond == 2 ? 32'h0000_0100 : 32'h00DD_0080);
    @(negedge CLK);
    chk("b2b drained", 32'(bus.rsp_valid), 32'h0);

    // Reset in the middle of a job.
    bus.angle_in[1] = 32'h002D_0000;
    bus.req[1] = 1'b1;
    @(negedge CLK);
    chk("rst gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    repeat (5) @(negedge CLK);
    chk("rst in run", 32'(core_en), 32'h1);
    RST = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge CLK);
    RST = 1'b0;
    wait_rsp(20, ok);
    chk("rst aborted", 32'(ok), 32'h0);
    run_vec('{2, 32'h002D_0000, 32'h00B5_00B5}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
